// File: rtl/mem_stage.sv
// mem_stage: memory-access stage that sits after the execute ALU.
// It takes one instruction at a time from execute and handles the data-memory
// request/response handshake for LW/LBU/SW/SB. It then presents exactly one
// writeback beat per instruction.
// Optional build macro: MEM_MISALIGN_TRAP_EN. When it is defined, a misaligned
// LW/SW skips memory and instead raises a one-beat misalign_o flag.

module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  // execute side
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [2:0]        ex_op_i,
  input  logic [31:0]       ex_result_i,
  input  logic [31:0]       ex_store_data_i,
  input  logic [4:0]        ex_rd_addr_i,
  input  logic              ex_wen_i,
  // data memory side
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_wdata_o,
  output logic [3:0]        dmem_be_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
  // writeback side
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic              wb_wen_o,
  output logic [4:0]        wb_rd_addr_o,
  output logic [31:0]       wb_data_o,
  output logic              misalign_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [2:0] OP_LW  = 3'd1;
  localparam logic [2:0] OP_LBU = 3'd2;
  localparam logic [2:0] OP_SW  = 3'd3;
  localparam logic [2:0] OP_SB  = 3'd4;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic              r_we;
  logic              r_is_byte;
  logic [1:0]        r_lane;
  logic [4:0]        r_rd;
  logic              r_wen;
  logic [31:0]       r_wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              r_misalign;
`endif

  logic       w_is_lw, w_is_lbu, w_is_sw, w_is_sb, w_is_mem, w_is_store, w_is_byte;
  logic [1:0] w_lane;
  logic [3:0] w_lane_be;
  logic       w_misalign;
  logic       w_accept;
  logic [7:0] w_rbyte;
  logic       w_in_req, w_in_wb;

  // Decode the incoming op. Opcodes 5-7 fall through as PASS.
  assign w_is_lw    = (ex_op_i == OP_LW);
  assign w_is_lbu   = (ex_op_i == OP_LBU);
  assign w_is_sw    = (ex_op_i == OP_SW);
  assign w_is_sb    = (ex_op_i == OP_SB);
  assign w_is_mem   = w_is_lw | w_is_lbu | w_is_sw | w_is_sb;
  assign w_is_store = w_is_sw | w_is_sb;
  assign w_is_byte  = w_is_lbu | w_is_sb;
  assign w_lane     = ex_result_i[1:0];
  assign w_lane_be  = 4'b0001 << w_lane;

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = (w_is_lw | w_is_sw) & (w_lane != 2'b00);
`else
  // Word accesses simply use the aligned word, so nothing is treated as misaligned.
  assign w_misalign = 1'b0;
`endif

  assign w_in_req = (r_state == S_REQ);
  assign w_in_wb  = (r_state == S_WB);

  // A new instruction can enter while the WB beat is being consumed.
  // This keeps PASS throughput at one instruction per cycle.
  assign ex_ready_o = (r_state == S_IDLE) | (w_in_wb & wb_ready_i);
  assign w_accept   = ex_valid_i & ex_ready_o;

  // LBU selects the addressed byte lane of the returned word.
  assign w_rbyte = dmem_rdata_i[{r_lane, 3'b000} +: 8];

  // The memory interface is driven only in REQ and reads as all-zero otherwise.
  assign dmem_req_o   = w_in_req;
  assign dmem_we_o    = w_in_req & r_we;
  assign dmem_addr_o  = w_in_req ? r_addr  : '0;
  assign dmem_wdata_o = w_in_req ? r_wdata : 32'h0;
  assign dmem_be_o    = w_in_req ? r_be    : 4'h0;

  // The writeback outputs are gated by WB, so they are zero whenever no beat is presented.
  assign wb_valid_o   = w_in_wb;
  assign wb_wen_o     = w_in_wb & r_wen;
  assign wb_rd_addr_o = w_in_wb ? r_rd      : 5'd0;
  assign wb_data_o    = w_in_wb ? r_wb_data : 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_o   = w_in_wb & r_misalign;
`else
  assign misalign_o   = 1'b0;
`endif

  // Sequencing: latch an accepted instruction, then step REQ -> WAIT -> WB.
  // A reset drops any response that is still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_be       <= 4'h0;
      r_we       <= 1'b0;
      r_is_byte  <= 1'b0;
      r_lane     <= 2'b00;
      r_rd       <= 5'd0;
      r_wen      <= 1'b0;
      r_wb_data  <= 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else if (w_accept) begin
      r_addr     <= {ex_result_i[ADDR_W-1:2], 2'b00};
      r_we       <= w_is_store;
      r_is_byte  <= w_is_byte;
      r_lane     <= w_lane;
      r_rd       <= ex_rd_addr_i;
      r_be       <= w_is_byte ? w_lane_be : 4'hF;
      r_wdata    <= w_is_sb ? {4{ex_store_data_i[7:0]}} :
                    (w_is_sw ? ex_store_data_i : 32'h0);
      r_wen      <= (w_is_store | w_misalign) ? 1'b0 : ex_wen_i;
      r_wb_data  <= w_is_mem ? 32'h0 : ex_result_i;
`ifdef MEM_MISALIGN_TRAP_EN
      r_misalign <= w_misalign;
`endif
      r_state    <= (w_is_mem & ~w_misalign) ? S_REQ : S_WB;
    end else begin
      case (r_state)
        S_REQ: begin
          if (dmem_gnt_i) begin
            r_state <= r_we ? S_WB : S_WAIT;
          end
        end
        S_WAIT: begin
          if (dmem_rvalid_i) begin
            r_wb_data <= r_is_byte ? {24'h0, w_rbyte} : dmem_rdata_i;
            r_state   <= S_WB;
          end
        end
        S_WB: begin
          if (wb_ready_i) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage. It steps through a linear sequence of hand-computed vectors.
// Inputs are driven 1 ns after the rising edge, and outputs are sampled 1 ns after that.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [2:0]  ex_op_i;
  logic [31:0] ex_result_i;
  logic [31:0] ex_store_data_i;
  logic [4:0]  ex_rd_addr_i;
  logic        ex_wen_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic        wb_wen_o;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage #(.ADDR_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_valid_i     (ex_valid_i),
    .ex_ready_o     (ex_ready_o),
    .ex_op_i        (ex_op_i),
    .ex_result_i    (ex_result_i),
    .ex_store_data_i(ex_store_data_i),
    .ex_rd_addr_i   (ex_rd_addr_i),
    .ex_wen_i       (ex_wen_i),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_be_o      (dmem_be_o),
    .dmem_gnt_i     (dmem_gnt_i),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .dmem_rdata_i   (dmem_rdata_i),
    .wb_valid_o     (wb_valid_o),
    .wb_ready_i     (wb_ready_i),
    .wb_wen_o       (wb_wen_o),
    .wb_rd_addr_o   (wb_rd_addr_o),
    .wb_data_o      (wb_data_o),
    .misalign_o     (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] res,
                       input logic [31:0] sdata, input logic [4:0] rd, input logic wen);
    ex_valid_i      = 1'b1;
    ex_op_i         = op;
    ex_result_i     = res;
    ex_store_data_i = sdata;
    ex_rd_addr_i    = rd;
    ex_wen_i        = wen;
  endtask

  initial begin
    reset = 1'b1;
    ex_valid_i = 1'b0; ex_op_i = 3'd0; ex_result_i = 32'h0; ex_store_data_i = 32'h0;
    ex_rd_addr_i = 5'd0; ex_wen_i = 1'b0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0; wb_ready_i = 1'b1;
    #1;
    chk("rst_ready", 32'(ex_ready_o), 32'd1);
    chk("rst_wbv",   32'(wb_valid_o), 32'd0);
    chk("rst_req",   32'(dmem_req_o), 32'd0);
    chk("rst_be",    32'(dmem_be_o),  32'd0);
    chk("rst_mis",   32'(misalign_o), 32'd0);
    tick(); tick();
    reset = 1'b0;

    // Back-to-back PASS ops
    issue(3'd0, 32'h11, 32'h0, 5'd1, 1'b1); #1;
    chk("pass_rdy0", 32'(ex_ready_o), 32'd1);
    tick(); issue(3'd0, 32'h22, 32'h0, 5'd1, 1'b1); #1;
    chk("pass_v1",   32'(wb_valid_o), 32'd1);
    chk("pass_d1",   wb_data_o, 32'h11);
    chk("pass_rdy1", 32'(ex_ready_o), 32'd1);
    tick(); issue(3'd0, 32'h33, 32'h0, 5'd1, 1'b1); #1;
    chk("pass_d2",   wb_data_o, 32'h22);
    chk("pass_rdy2", 32'(ex_ready_o), 32'd1);
    tick(); ex_valid_i = 1'b0; #1;
    chk("pass_d3",   wb_data_o, 32'h33);
    chk("pass_wen",  32'(wb_wen_o), 32'd1);
    chk("pass_rd",   32'(wb_rd_addr_o), 32'd1);
    tick();
    chk("pass_idle", 32'(wb_valid_o), 32'd0);

    // LW at 0x100, with two stall cycles before grant
    issue(3'd1, 32'h100, 32'h0, 5'd2, 1'b1);
    tick(); ex_valid_i = 1'b0; #1;
    chk("lw_req",  32'(dmem_req_o), 32'd1);
    chk("lw_we",   32'(dmem_we_o), 32'd0);
    chk("lw_be",   32'(dmem_be_o), 32'hF);
    chk("lw_addr0", dmem_addr_o, 32'h100);
    tick();
    chk("lw_addr1", dmem_addr_o, 32'h100);
    tick();
    chk("lw_addr2", dmem_addr_o, 32'h100);
    chk("lw_rdy",   32'(ex_ready_o), 32'd0);
    dmem_gnt_i = 1'b1;
    tick(); dmem_gnt_i = 1'b0; #1;
    chk("lw_wait_req", 32'(dmem_req_o), 32'd0);
    chk("lw_wait_wbv", 32'(wb_valid_o), 32'd0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFEF00D;
    tick(); dmem_rvalid_i = 1'b0; #1;
    chk("lw_wbv",  32'(wb_valid_o), 32'd1);
    chk("lw_data", wb_data_o, 32'hCAFEF00D);
    chk("lw_wen",  32'(wb_wen_o), 32'd1);
    chk("lw_rd",   32'(wb_rd_addr_o), 32'd2);
    tick();

    // LBU at 0x203, which selects byte lane 3
    issue(3'd2, 32'h203, 32'h0, 5'd3, 1'b1);
    tick(); ex_valid_i = 1'b0; #1;
    chk("lbu_be",   32'(dmem_be_o), 32'h8);
    chk("lbu_addr", dmem_addr_o, 32'h200);
    dmem_gnt_i = 1'b1;
    tick(); dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h80FF1234;
    tick(); dmem_rvalid_i = 1'b0; #1;
    chk("lbu_data", wb_data_o, 32'h00000080);
    chk("lbu_wen",  32'(wb_wen_o), 32'd1);
    tick();

    // SB at 0x41, with data 0xAB
    issue(3'd4, 32'h41, 32'h000000AB, 5'd4, 1'b1);
    tick(); ex_valid_i = 1'b0; #1;
    chk("sb_wdata", dmem_wdata_o, 32'hABABABAB);
    chk("sb_be",    32'(dmem_be_o), 32'h2);
    chk("sb_we",    32'(dmem_we_o), 32'd1);
    chk("sb_addr",  dmem_addr_o, 32'h40);
    dmem_gnt_i = 1'b1;
    tick(); dmem_gnt_i = 1'b0; #1;
    chk("sb_wbv", 32'(wb_valid_o), 32'd1);
    chk("sb_wen", 32'(wb_wen_o), 32'd0);
    chk("sb_req", 32'(dmem_req_o), 32'd0);
    tick();

    // Writeback stall while the next instruction is waiting
    wb_ready_i = 1'b0;
    issue(3'd0, 32'h55, 32'h0, 5'd5, 1'b1);
    tick(); issue(3'd0, 32'h66, 32'h0, 5'd6, 1'b1); #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_rdy",  32'(ex_ready_o), 32'd0);
      chk("stall_data", wb_data_o, 32'h55);
      chk("stall_rd",   32'(wb_rd_addr_o), 32'd5);
      if (i < 2) tick();
    end
    wb_ready_i = 1'b1; #1;
    chk("rel_rdy", 32'(ex_ready_o), 32'd1);
    tick(); ex_valid_i = 1'b0; #1;
    chk("rel_data", wb_data_o, 32'h66);
    chk("rel_rd",   32'(wb_rd_addr_o), 32'd6);
    tick();

    // Reset during WAIT of an LW, followed by a late rvalid
    issue(3'd1, 32'h300, 32'h0, 5'd7, 1'b1);
    tick(); ex_valid_i = 1'b0; dmem_gnt_i = 1'b1;
    tick(); dmem_gnt_i = 1'b0;
    reset = 1'b1; #1;
    chk("mrst_rdy", 32'(ex_ready_o), 32'd1);
    chk("mrst_wbv", 32'(wb_valid_o), 32'd0);
    chk("mrst_req", 32'(dmem_req_o), 32'd0);
    tick(); reset = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h12345678;
    tick(); dmem_rvalid_i = 1'b0; #1;
    chk("late_wbv",  32'(wb_valid_o), 32'd0);
    chk("late_data", wb_data_o, 32'h0);
    tick();
    chk("late_wbv2", 32'(wb_valid_o), 32'd0);

    // Misaligned SW at 0x102
    issue(3'd3, 32'h102, 32'hDEADBEEF, 5'd8, 1'b1);
    tick(); ex_valid_i = 1'b0; #1;
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_req",  32'(dmem_req_o), 32'd0);
    chk("mis_wbv",  32'(wb_valid_o), 32'd1);
    chk("mis_flag", 32'(misalign_o), 32'd1);
    chk("mis_wen",  32'(wb_wen_o), 32'd0);
    chk("mis_data", wb_data_o, 32'h0);
    tick();
    chk("mis_flag_off", 32'(misalign_o), 32'd0);
`else
    chk("sw_req",   32'(dmem_req_o), 32'd1);
    chk("sw_addr",  dmem_addr_o, 32'h100);
    chk("sw_be",    32'(dmem_be_o), 32'hF);
    chk("sw_wdata", dmem_wdata_o, 32'hDEADBEEF);
    chk("sw_mis",   32'(misalign_o), 32'd0);
    dmem_gnt_i = 1'b1;
    tick(); dmem_gnt_i = 1'b0; #1;
    chk("sw_wen", 32'(wb_wen_o), 32'd0);
    chk("sw_wbv", 32'(wb_valid_o), 32'd1);
    tick();
`endif
    chk("end_idle", 32'(wb_valid_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute ALU in the cse141l core.
- Takes the ALU result as either a load/store address or a pass-through value.
- Runs the data-memory request/response handshake for word and byte loads and stores, then presents one writeback beat per instruction to the register-file writeback.
- Holds one instruction at a time and back-pressures execute through a valid/ready handshake.

Parameters:
ADDR_W  32  width of dmem_addr_o; low ADDR_W bits of ex_result_i used

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high reset
ex_valid_i  input  1  execute presents an instruction
ex_ready_o  output  1  stage can accept an instruction this cycle
ex_op_i  input  3  0=PASS (non-memory), 1=LW, 2=LBU, 3=SW, 4=SB; 5-7 treated as PASS
ex_result_i  input  32  ALU result: address for LW/LBU/SW/SB, writeback value for PASS
ex_store_data_i  input  32  store data for SW/SB
ex_rd_addr_i  input  5  destination register
ex_wen_i  input  1  instruction writes a register (PASS/LW/LBU)
dmem_req_o  output  1  memory request valid
dmem_we_o  output  1  1=store, 0=load
dmem_addr_o  output  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}
dmem_wdata_o  output  32  store data
dmem_be_o  output  4  byte enables
dmem_gnt_i  input  1  memory accepts request
dmem_rvalid_i  input  1  load data valid
dmem_rdata_i  input  32  load data word
wb_valid_o  output  1  writeback beat valid
wb_ready_i  input  1  writeback accepts beat
wb_wen_o  output  1  register write enable
wb_rd_addr_o  output  5  destination register
wb_data_o  output  32  writeback data
misalign_o  output  1  misaligned-access flag (see Optional Feature)

Behaviour:
- FSM states:
  - IDLE: ex_ready_o=1.
  - REQ: dmem_req_o=1, held with stable addr/we/wdata/be until dmem_gnt_i.
  - WAIT: waiting for dmem_rvalid_i.
  - WB: wb_valid_o=1, outputs held stable until wb_ready_i.
- ex_ready_o = (state==IDLE) | (state==WB & wb_ready_i). All fields latched on ex_valid_i & ex_ready_o.
- Accept transitions: PASS -> WB; LW/LBU/SW/SB -> REQ.
- REQ & gnt: loads -> WAIT; stores -> WB with wb_wen_o=0.
- WAIT & rvalid -> WB. dmem_rvalid_i arrives no earlier than the cycle after gnt; rvalid outside WAIT is ignored.
- WB & wb_ready_i: accepts a new instruction the same cycle if ex_valid_i, else -> IDLE.
- Latency from accept cycle N:
  - PASS: wb_valid_o at N+1; sustains 1 instruction/cycle when wb_ready_i=1.
  - Load with gnt in N+1 and rvalid in N+2: wb_valid_o at N+3.
  - Store with gnt in N+1: wb_valid_o at N+2.
- Byte handling, with a = address[1:0]:
  - SW: be=4'hF, wdata=store data.
  - SB: be=4'b0001<<a, wdata=store_data[7:0] replicated in all four lanes.
  - LW: be=4'hF, wb_data=rdata.
  - LBU: be=4'b0001<<a, wb_data = zero-extended rdata byte a.
- wb_wen_o is ex_wen_i latched for PASS/LW/LBU; forced 0 for SW/SB.
- Memory outputs are 0 outside REQ (dmem_req_o, dmem_we_o, dmem_be_o = 0).
- Reset (any time, including mid-transaction):
  - state=IDLE.
  - All outputs 0 except ex_ready_o=1.
  - Any outstanding memory response is dropped.
- Simultaneous ex_valid_i with WB & !wb_ready_i: nothing is accepted and the WB beat holds.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined:
  - LW/SW with address[1:0]!=0 skips REQ and goes straight to WB.
  - wb_wen_o=0, wb_data_o=32'h0, misalign_o=1 for that beat only.
  - No memory request is issued.
- Undefined:
  - misalign_o is tied 0.
  - Low address bits are ignored for LW/SW; the access uses the aligned word.

Test Plan:
- PASS ops 0x11, 0x22, 0x33 back-to-back, wb_ready_i=1 -> wb_data_o 0x11/0x22/0x33 on consecutive cycles, ex_ready_o stays 1.
- LW addr 0x100, gnt after 2 stall cycles, rvalid the next cycle with 0xCAFEF00D -> dmem_addr_o held at 0x100 through the stall; wb_data_o=0xCAFEF00D, wb_wen_o=1.
- LBU addr 0x203, rdata 0x80FF1234 -> dmem_be_o=4'b1000, wb_data_o=0x00000080.
- SB addr 0x41, data 0x000000AB -> dmem_wdata_o=0xABABABAB, dmem_be_o=4'b0010, dmem_we_o=1; wb beat has wb_wen_o=0.
- PASS result while wb_ready_i=0 for 3 cycles -> ex_ready_o=0 and wb outputs stable; release -> next instruction accepted in the release cycle.
- reset asserted in WAIT of a LW, late rvalid after reset deasserts -> outputs 0, no wb_valid_o; with MEM_MISALIGN_TRAP_EN, SW addr 0x102 -> no dmem_req_o, misalign_o=1 for one beat.
